btn_debounce: RTL and testbench



---
 rtl/btn_debounce.sv | 106 ++++++++++
 tb/tb_btn_debounce.sv | 139 +++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Two-channel push-button conditioner: 2-flop synchronizer, debounce FSM,
// registered level plus one-cycle press/release ticks per button.

module btn_debounce_ch #(
   parameter int N = 19
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic tick,
   output logic rel
);

   // Bit 1 of the encoding is the debounced level, so level falls out of the state.
   localparam logic [1:0] ZERO  = 2'b00;
   localparam logic [1:0] WAIT1 = 2'b01;
   localparam logic [1:0] ONE   = 2'b10;
   localparam logic [1:0] WAIT0 = 2'b11;

   localparam logic [N-1:0] M = '1;

   logic         s1, s;
   logic [1:0]   state, state_nxt;
   logic [N-1:0] cnt, cnt_nxt;
   logic         tick_nxt, rel_nxt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tick_nxt  = 1'b0;
      rel_nxt   = 1'b0;
      case (state)
         ZERO: if (s) begin
            state_nxt = WAIT1;
            cnt_nxt   = M;
         end
         WAIT1: if (!s) begin
            state_nxt = ZERO;
         end else if (cnt == '0) begin
            state_nxt = ONE;
            tick_nxt  = 1'b1;
         end else begin
            cnt_nxt = cnt - N'(1);
         end
         ONE: if (!s) begin
            state_nxt = WAIT0;
            cnt_nxt   = M;
         end
         WAIT0: if (s) begin
            state_nxt = ONE;
         end else if (cnt == '0) begin
            state_nxt = ZERO;
            rel_nxt   = 1'b1;
         end else begin
            cnt_nxt = cnt - N'(1);
         end
         default: state_nxt = ZERO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b0;
         s     <= 1'b0;
         state <= ZERO;
         cnt   <= '0;
         level <= 1'b0;
         tick  <= 1'b0;
         rel   <= 1'b0;
      end else begin
         s1    <= raw;
         s     <= s1;
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= state_nxt[1];
         tick  <= tick_nxt;
         rel   <= rel_nxt;
      end
   end

endmodule

module btn_debounce #(
   parameter int N = 19
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] btn_raw,
   output logic [1:0] db_level,
   output logic [1:0] db_tick,
   output logic [1:0] rel_tick
);

   for (genvar i = 0; i < 2; i++) begin : g_ch
      btn_debounce_ch #(.N(N)) u_ch (
         .clk   (clk),
         .reset (reset),
         .raw   (btn_raw[i]),
         .level (db_level[i]),
         .tick  (db_tick[i]),
         .rel   (rel_tick[i])
      );
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Vector-table bench for btn_debounce at N=3: each record is one clock of
// stimulus and the outputs expected right after that edge.

module tb_btn_debounce;

   typedef struct {
      logic       rst;
      logic [1:0] raw;
      logic [1:0] lvl;
      logic [1:0] tick;
      logic [1:0] rel;
      string      tag;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] btn_raw;
   logic [1:0] db_level, db_tick, rel_tick;

   int errors = 0;
   int checks = 0;

   vec_t  vecs[$];
   vec_t  sb[$];
   string cur_tag;

   btn_debounce #(.N(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_raw  (btn_raw),
      .db_level (db_level),
      .db_tick  (db_tick),
      .rel_tick (rel_tick)
   );

   always #5 clk = ~clk;

   task automatic seg(input logic rst, input logic [1:0] raw, input logic [1:0] lvl,
                      input logic [1:0] tick, input logic [1:0] rel, input int n);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.rst = rst; v.raw = raw; v.lvl = lvl; v.tick = tick; v.rel = rel; v.tag = cur_tag;
         vecs.push_back(v);
      end
   endtask

   initial begin
      vec_t       e;
      logic [1:0] prev_tick = 2'b00;
      logic [1:0] prev_rel  = 2'b00;

      // reset state
      cur_tag = "reset";
      seg(1, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      // 1: channel 0 press, tick after edge 10
      cur_tag = "press0";
      seg(0, 2'b01, 2'b00, 2'b00, 2'b00, 10);
      seg(0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
      seg(0, 2'b01, 2'b01, 2'b00, 2'b00, 5);
      // 2: channel 1 press, release at edge 30
      cur_tag = "press1";
      seg(0, 2'b11, 2'b01, 2'b00, 2'b00, 10);
      seg(0, 2'b11, 2'b11, 2'b10, 2'b00, 1);
      seg(0, 2'b11, 2'b11, 2'b00, 2'b00, 19);
      cur_tag = "release1";
      seg(0, 2'b01, 2'b11, 2'b00, 2'b00, 10);
      seg(0, 2'b01, 2'b01, 2'b00, 2'b10, 1);
      seg(0, 2'b01, 2'b01, 2'b00, 2'b00, 4);
      // 3: bounce on channel 1, final rise at edge 12, tick at edge 22
      cur_tag = "bounce1";
      seg(0, 2'b11, 2'b01, 2'b00, 2'b00, 3);
      seg(0, 2'b01, 2'b01, 2'b00, 2'b00, 3);
      seg(0, 2'b11, 2'b01, 2'b00, 2'b00, 3);
      seg(0, 2'b01, 2'b01, 2'b00, 2'b00, 3);
      seg(0, 2'b11, 2'b01, 2'b00, 2'b00, 10);
      seg(0, 2'b11, 2'b11, 2'b10, 2'b00, 1);
      seg(0, 2'b11, 2'b11, 2'b00, 2'b00, 3);
      // 4: 4-clock drop on channel 1 while in ONE
      cur_tag = "drop1";
      seg(0, 2'b01, 2'b11, 2'b00, 2'b00, 4);
      seg(0, 2'b11, 2'b11, 2'b00, 2'b00, 12);
      // simultaneous release
      cur_tag = "rel_both";
      seg(0, 2'b00, 2'b11, 2'b00, 2'b00, 10);
      seg(0, 2'b00, 2'b00, 2'b00, 2'b11, 1);
      seg(0, 2'b00, 2'b00, 2'b00, 2'b00, 3);
      // 5: simultaneous press
      cur_tag = "press_both";
      seg(0, 2'b11, 2'b00, 2'b00, 2'b00, 10);
      seg(0, 2'b11, 2'b11, 2'b11, 2'b00, 1);
      seg(0, 2'b11, 2'b11, 2'b00, 2'b00, 3);
      cur_tag = "rel_both2";
      seg(0, 2'b00, 2'b11, 2'b00, 2'b00, 10);
      seg(0, 2'b00, 2'b00, 2'b00, 2'b11, 1);
      seg(0, 2'b00, 2'b00, 2'b00, 2'b00, 3);
      // 6: reset at edge 6 mid-WAIT1, re-debounce to tick at edge 17
      cur_tag = "rst_mid";
      seg(0, 2'b01, 2'b00, 2'b00, 2'b00, 6);
      seg(1, 2'b01, 2'b00, 2'b00, 2'b00, 1);
      seg(0, 2'b01, 2'b00, 2'b00, 2'b00, 10);
      seg(0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
      seg(0, 2'b01, 2'b01, 2'b00, 2'b00, 3);
      // reset while level is high clears it
      cur_tag = "rst_high";
      seg(1, 2'b01, 2'b00, 2'b00, 2'b00, 1);
      seg(0, 2'b00, 2'b00, 2'b00, 2'b00, 3);

      reset   = 1'b1;
      btn_raw = 2'b00;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset   = vecs[i].rst;
         btn_raw = vecs[i].raw;
         sb.push_back(vecs[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if (db_level !== e.lvl || db_tick !== e.tick || rel_tick !== e.rel) begin
            errors++;
            $display("FAIL %s vec%0d: got lvl=%b tick=%b rel=%b, want lvl=%b tick=%b rel=%b",
                     e.tag, i, db_level, db_tick, rel_tick, e.lvl, e.tick, e.rel);
         end
         // ticks never overlap each other nor repeat on consecutive cycles
         checks++;
         if (((db_tick & rel_tick) | (db_tick & prev_tick) | (rel_tick & prev_rel)) !== 2'b00) begin
            errors++;
            $display("FAIL tick_excl vec%0d: got tick=%b rel=%b prev_tick=%b prev_rel=%b, want no overlap",
                     i, db_tick, rel_tick, prev_tick, prev_rel);
         end
         prev_tick = db_tick;
         prev_rel  = rel_tick;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
